cm_sort_drain: RTL
==================

Name: cm_sort_drain

Overview:
- Receiving end of the parallel sorter's output vector interface.
- Accepts a complete sorted vector in one beat (valid only, no ready), buffers up to FDEPTH vectors, and serializes them one element per cycle on a valid/ready stream.
- Optionally emits in descending order and suppresses adjacent duplicates.
- Typical use: a sorter followed by this block, feeding a narrow downstream consumer.

Parameters:
- DCNT, 4, elements per input vector; must be ≥ 2.
- DWIDTH, 8, bits per element.
- FDEPTH, 2, number of buffered vectors; must be ≥ 1.
- DESC, 0, 0 = emit index 0 first (ascending); 1 = emit index DCNT-1 first.
- UNIQ, 0, 1 = skip any element equal to its emit-order predecessor within the same vector.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_vld  in  1  input vector valid.
- i_data  in  DCNT*DWIDTH  sorted vector, packed [DCNT-1:0][DWIDTH-1:0].
- o_rdy  out  1  buffer can accept a vector this cycle (advisory; the upstream sorter has no stall).
- o_ovf  out  1  sticky overflow; set when i_vld=1 while o_rdy=0.
- o_lvl  out  $clog2(FDEPTH+1)  number of occupied vector slots.
- o_vld  out  1  output element valid.
- o_data  out  DWIDTH  output element.
- o_idx  out  $clog2(DCNT)  source index of o_data within its vector.
- o_last  out  1  o_data is the final emitted element of its vector.
- i_rdy  in  1  downstream ready.

Behaviour:
- Reset (synchronous, active-high) values: o_vld=0, o_ovf=0, o_lvl=0, o_rdy=1, o_data=0, o_idx=0, o_last=0. Reset mid-burst discards all buffered vectors and the current emit position.
- Write:
  - A vector is accepted when i_vld && o_rdy.
  - A keep mask is computed at write time and stored beside the vector.
  - UNIQ=0: keep = all ones.
  - UNIQ=1: the first element in emit order is always kept; element k is kept iff it differs from its emit-order neighbour (k-1 when DESC=0, k+1 when DESC=1).
- o_rdy = (o_lvl < FDEPTH) || (head vector completes this cycle: o_vld && i_rdy && o_last). Simultaneous final read and write when full is allowed.
- Overflow: i_vld && !o_rdy drops the vector. o_ovf goes high the next cycle and stays high until reset.
- Latency: a vector accepted in cycle t into an empty buffer presents its first kept element with o_vld=1 in cycle t+1. No combinational path from i_vld/i_data to o_*.
- Read FSM, two states:
  - IDLE: o_vld=0. Move to EMIT when o_lvl > 0.
  - EMIT: o_vld=1. o_data/o_idx point at the current kept element.
- Handshake: on o_vld && i_rdy, advance to the next kept index in emit order.
  - If that element was o_last, pop the head vector. Go to IDLE if no vector remains; otherwise load the next vector's first kept index in the same cycle, so there are no bubbles between vectors.
  - While o_vld && !i_rdy, o_data, o_idx and o_last hold stable.
- o_last = no kept index remains after the current one in emit order.
- Circular slot pointers wrap modulo FDEPTH. o_lvl increments on write, decrements on pop, and is unchanged when both occur in the same cycle.
- Arithmetic: equality compare only. Element values are never modified.

Decomposition:
- cm_pkg additions:
  - typedef t_drain_ord (enum DRAIN_ASC, DRAIN_DESC), used for the DESC decode.
  - function next_keep_idx(mask, cur, desc), used by both the FSM and o_last.
- One sub-module, cm_sort_keep: combinational keep-mask generator (DCNT, DWIDTH, DESC, UNIQ → DCNT-bit mask).
- Storage and FSM stay in cm_sort_drain.

Test Plan:
- DCNT=4, DWIDTH=8, DESC=0, UNIQ=0. Single vector {idx0..3}={3,7,9,12}, i_rdy=1 → o_data 3,7,9,12 in cycles t+1..t+4; o_idx 0..3; o_last only on 12.
- DESC=1, same vector → o_data 12,9,7,3; o_idx 3,2,1,0; o_last on 3.
- UNIQ=1, DESC=0, vector {5,5,5,8} → emits 5 (idx0), 8 (idx3, o_last). Vector {4,4,4,4} → emits a single 4 with o_last=1.
- FDEPTH=2, i_rdy=0, three vectors on consecutive cycles → first two accepted (o_lvl=2, o_rdy=0); third dropped; o_ovf=1 from the next cycle. Then i_rdy=1 → exactly 8 elements out, o_ovf still 1.
- Full buffer, write coincident with final pop (o_last && i_rdy) → write accepted, o_lvl stays 2, o_ovf stays 0, next vector's first element in the following cycle with no gap.
- i_rst asserted mid-vector (after 2 of 4 elements) → next cycle o_vld=0, o_lvl=0, o_ovf=0; a new vector then emits from its first element.

Source files
------------

// File: rtl/cm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cm_pkg                                                               |
// | Shared types and helpers for the sorter drain datapath.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cm_pkg;

    localparam int c_max_dcnt = 64;

    typedef enum logic {
        DRAIN_ASC  = 1'b0,
        DRAIN_DESC = 1'b1
    } t_drain_ord;

    // Next kept index after cur in emit order, or -1 when none remains.
    function automatic int next_keep_idx(
        input logic [c_max_dcnt-1:0] mask,
        input int                    cur,
        input t_drain_ord            desc
    );
        int res;
        res = -1;
        for (int k = 0; k < c_max_dcnt; k++) begin
            if (mask[k]) begin
                if (desc == DRAIN_ASC) begin
                    if ((k > cur) && (res < 0)) begin
                        res = k;
                    end
                end else if (k < cur) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cm_sort_keep.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cm_sort_keep                                                         |
// | Combinational keep-mask generator for adjacent-duplicate removal.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cm_sort_keep
    import cm_pkg::*;
#(
    parameter int DCNT   = 4,
    parameter int DWIDTH = 8,
    parameter int DESC   = 0,
    parameter int UNIQ   = 0
)(
    input  logic [DCNT*DWIDTH-1:0] i_data,
    output logic [DCNT-1:0]        o_keep
);

    localparam t_drain_ord c_ord = (DESC != 0) ? DRAIN_DESC : DRAIN_ASC;

    for (genvar k = 0; k < DCNT; k++) begin : g_elem
        if (UNIQ == 0) begin : g_all
            assign o_keep[k] = 1'b1;
        end else if (c_ord == DRAIN_ASC) begin : g_asc
            if (k == 0) begin : g_first
                assign o_keep[k] = 1'b1;
            end else begin : g_cmp
                assign o_keep[k] = (i_data[k*DWIDTH +: DWIDTH] != i_data[(k-1)*DWIDTH +: DWIDTH]);
            end
        end else begin : g_desc
            if (k == DCNT-1) begin : g_first
                assign o_keep[k] = 1'b1;
            end else begin : g_cmp
                assign o_keep[k] = (i_data[k*DWIDTH +: DWIDTH] != i_data[(k+1)*DWIDTH +: DWIDTH]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cm_sort_drain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cm_sort_drain                                                        |
// | Buffers whole sorted vectors and serializes them one element/cycle.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cm_sort_drain
    import cm_pkg::*;
#(
    parameter int DCNT   = 4,
    parameter int DWIDTH = 8,
    parameter int FDEPTH = 2,
    parameter int DESC   = 0,
    parameter int UNIQ   = 0
)(
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_vld,
    input  logic [DCNT*DWIDTH-1:0]       i_data,
    output logic                         o_rdy,
    output logic                         o_ovf,
    output logic [$clog2(FDEPTH+1)-1:0]  o_lvl,
    output logic                         o_vld,
    output logic [DWIDTH-1:0]            o_data,
    output logic [$clog2(DCNT)-1:0]      o_idx,
    output logic                         o_last,
    input  logic                         i_rdy
);

    localparam int c_iw = $clog2(DCNT);
    localparam int c_lw = $clog2(FDEPTH+1);
    localparam int c_pw = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int c_vw = DCNT*DWIDTH;
    localparam t_drain_ord c_ord = (DESC != 0) ? DRAIN_DESC : DRAIN_ASC;
    // The first element in emit order is always kept, so every vector starts here.
    localparam logic [c_iw-1:0] c_first_idx = (c_ord == DRAIN_DESC) ? c_iw'(DCNT-1) : '0;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_emit = 1'b1;

    logic [c_vw-1:0] mem_q  [FDEPTH];
    logic [c_vw-1:0] mem_d  [FDEPTH];
    logic [DCNT-1:0] keep_q [FDEPTH];
    logic [DCNT-1:0] keep_d [FDEPTH];
    logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_lw-1:0] lvl_q, lvl_d;
    logic            ovf_q, ovf_d;
    logic [0:0]      state_q, state_d;
    logic [c_iw-1:0] cur_q, cur_d;

    logic [DCNT-1:0] w_keep;
    logic [c_vw-1:0] w_head_data;
    logic [DCNT-1:0] w_head_keep;
    int              w_nxt;
    logic [c_iw-1:0] w_nxt_idx;
    logic            w_last;
    logic            w_emit;
    logic            w_pop;
    logic            w_rdy;
    logic            w_wr;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(FDEPTH-1)) ? '0 : p + c_pw'(1);
    endfunction

    cm_sort_keep #(
        .DCNT   (DCNT),
        .DWIDTH (DWIDTH),
        .DESC   (DESC),
        .UNIQ   (UNIQ)
    ) u_keep (
        .i_data (i_data),
        .o_keep (w_keep)
    );

    always_comb begin
        w_head_data = mem_q[rd_ptr_q];
        w_head_keep = keep_q[rd_ptr_q];
        w_nxt       = next_keep_idx(c_max_dcnt'(w_head_keep), int'(cur_q), c_ord);
        w_nxt_idx   = c_iw'(w_nxt);
        w_last      = (w_nxt < 0);
        w_emit      = (state_q == c_st_emit);
        w_pop       = w_emit && i_rdy && w_last;
        w_rdy       = (lvl_q < c_lw'(FDEPTH)) || w_pop;
        w_wr        = i_vld && w_rdy;
    end

    always_comb begin
        mem_d  = mem_q;
        keep_d = keep_q;
        if (w_wr) begin
            mem_d[wr_ptr_q]  = i_data;
            keep_d[wr_ptr_q] = w_keep;
        end
        wr_ptr_d = w_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({w_wr, w_pop})
            2'b10:   lvl_d = lvl_q + c_lw'(1);
            2'b01:   lvl_d = lvl_q - c_lw'(1);
            default: lvl_d = lvl_q;
        endcase
        ovf_d = ovf_q || (i_vld && !w_rdy);
    end

    // Payload slots need no reset; occupancy alone says what is valid.
    always_ff @(posedge i_clk) begin
        mem_q  <= mem_d;
        keep_q <= keep_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= c_st_idle;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // Entering EMIT on the write itself gives the one-cycle first-element latency.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            c_st_idle: begin
                if ((lvl_q != '0) || w_wr) begin
                    state_d = c_st_emit;
                    cur_d   = c_first_idx;
                end
            end
            c_st_emit: begin
                if (i_rdy) begin
                    if (!w_last) begin
                        cur_d = w_nxt_idx;
                    end else begin
                        cur_d = c_first_idx;
                        if ((lvl_q == c_lw'(1)) && !w_wr) begin
                            state_d = c_st_idle;
                        end
                    end
                end
            end
            default: begin
                state_d = c_st_idle;
                cur_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_vld  = w_emit;
        o_data = w_emit ? w_head_data[cur_q*DWIDTH +: DWIDTH] : '0;
        o_idx  = w_emit ? cur_q : '0;
        o_last = w_emit && w_last;
        o_rdy  = w_rdy;
        o_ovf  = ovf_q;
        o_lvl  = lvl_q;
    end

endmodule
`default_nettype wire
